// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, fetch FSM states, reset PC default.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_JR       = 6'h08;  // funct field under OP_RTYPE
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Output register plus one skid entry for the fetch stage; flush empties both.
module fetch_skid_buffer
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc4,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc4,
  output logic               o_skid_valid
);

  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [ADDR_W-1:0]  r_out_pc4;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_pc4;
  logic               w_out_free;

  assign w_out_free = !r_out_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_pc4    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // skid is older than anything returning now, so it drains first
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_pc4    <= r_skid_pc4;
        r_skid_valid <= i_push;
        if (i_push) begin
          r_skid_instr <= i_instr;
          r_skid_pc4   <= i_pc4;
        end
      end else begin
        r_out_valid <= i_push;
        if (i_push) begin
          r_out_instr <= i_instr;
          r_out_pc4   <= i_pc4;
        end
      end
    end else if (i_push) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= i_instr;
      r_skid_pc4   <= i_pc4;
    end
  end

  assign o_valid      = r_out_valid;
  assign o_instr      = r_out_instr;
  assign o_pc4        = r_out_pc4;
  assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, BOOT/RUN/HALTED FSM, redirect muxing, imem interface to decode.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  input  logic               redir_jr,
  input  logic               redir_jal,
  input  logic               redir_br,
  input  logic [ADDR_W-1:0]  dec_pc_plus4,
  input  logic [25:0]        dec_index,
  input  logic [15:0]        dec_imm,
  input  logic [31:0]        redir_rs,
  input  logic               halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_pend_pc4, w_pc4, w_target;
  logic              r_pending;
  logic              w_redirect, w_flush, w_push, w_req, w_skid_valid;

  assign w_redirect = redir_jr | redir_jal | redir_br;
  assign w_pc4      = r_pc + ADDR_W'(4);

  always_comb begin
    w_target = dec_pc_plus4 + br_offset(dec_imm);
    if (redir_jal) w_target = {dec_pc_plus4[31:28], dec_index, 2'b00};
    if (redir_jr)  w_target = redir_rs;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = halt ? HALTED : RUN;
      RUN:     if (halt) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = BOOT;
    endcase
  end

  // At most one word in flight and the skid empty whenever a new request goes out
  assign w_req = (r_state == RUN) && !halt && !w_redirect && !w_skid_valid &&
                 !(r_pending && if_valid && !if_ready);

  assign w_flush = w_redirect || halt || (r_state == HALTED);
  assign w_push  = r_pending && !w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pending  <= 1'b0;
      r_pend_pc4 <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_req;
      if (w_redirect)  r_pc <= w_target;
      else if (w_req)  r_pc <= w_pc4;
      if (w_req) r_pend_pc4 <= w_pc4;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
    .clk          (clk),
    .rst          (reset),
    .i_flush      (w_flush),
    .i_push       (w_push),
    .i_instr      (imem_rdata),
    .i_pc4        (r_pend_pc4),
    .i_ready      (if_ready),
    .o_valid      (if_valid),
    .o_instr      (if_instr),
    .o_pc4        (if_pc_plus4),
    .o_skid_valid (w_skid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_squashed;
  logic [1:0]  w_sq_inc;
  logic [32:0] w_sq_sum;

  // squashed = buffered entries plus the word returning in the redirect cycle
  assign w_sq_inc = w_redirect ? ({1'b0, if_valid} + {1'b0, w_skid_valid} + {1'b0, r_pending}) : 2'd0;
  assign w_sq_sum = {1'b0, r_perf_squashed} + 33'(w_sq_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (if_valid && if_ready && !w_flush && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      r_perf_squashed <= w_sq_sum[32] ? '1 : w_sq_sum[31:0];
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: program-order reference stream vs. decode-side handshakes.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        redir_jr, redir_jal, redir_br;
  logic [31:0] dec_pc_plus4;
  logic [25:0] dec_index;
  logic [15:0] dec_imm;
  logic [31:0] redir_rs;
  logic        halt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc_plus4  (if_pc_plus4),
    .redir_jr     (redir_jr),
    .redir_jal    (redir_jal),
    .redir_br     (redir_br),
    .dec_pc_plus4 (dec_pc_plus4),
    .dec_index    (dec_index),
    .dec_imm      (dec_imm),
    .redir_rs     (redir_rs),
    .halt         (halt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // fixed one-cycle latency instruction memory
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: the decode side must see consecutive words from the last redirect/reset target
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  bit          sb_armed = 1'b0;

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
  endtask

  task automatic sb_topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  function automatic logic [31:0] model_target(input logic jr, input logic jal,
      input logic [31:0] rs, input logic [31:0] pc4, input logic [25:0] idx, input logic [15:0] imm);
    int off;
    if (jr) return rs;
    if (jal) return (pc4 & 32'hF000_0000) | ({6'b0, idx} << 2);
    off = int'($signed(imm)) * 4;
    return pc4 + 32'(off);
  endfunction

  int unsigned req_cnt = 0;
  int unsigned hs_cnt  = 0;
  logic        prev_req = 1'b0;

  // Monitor: pops the reference stream on every accepted output
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        req_cnt  = 0;
        hs_cnt   = 0;
        prev_req = 1'b0;
      end else begin
        if (if_valid && if_ready && !(redir_jr || redir_jal || redir_br) && !halt) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL sb_unexpected: got pc4 %h expected no output", if_pc_plus4);
          end else begin
            a = exp_q.pop_front();
            check("sb_pc4", if_pc_plus4, a + 32'd4);
            check("sb_instr", if_instr, mem_word(a));
            hs_cnt++;
          end
        end
        if (imem_req) req_cnt++;
        prev_req = imem_req;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(negedge clk);
    redir_jr  = 1'b0;
    redir_jal = 1'b0;
    redir_br  = 1'b0;
    halt      = 1'b0;
    if (sb_armed) sb_topup();
  endtask

  // decode never accepts in the cycle it redirects
  task automatic do_redirect(input logic jr, input logic jal, input logic br, input logic [31:0] rs,
                             input logic [31:0] pc4, input logic [25:0] idx, input logic [15:0] imm);
    redir_jr     = jr;
    redir_jal    = jal;
    redir_br     = br;
    redir_rs     = rs;
    dec_pc_plus4 = pc4;
    dec_index    = idx;
    dec_imm      = imm;
    if_ready     = 1'b0;
    sb_restart(model_target(jr, jal, rs, pc4, idx, imm));
    sb_topup();
  endtask

  initial begin
    logic [31:0] held_instr, held_pc4;
    logic [2:0]  k;

    reset = 1'b1; if_ready = 1'b1; halt = 1'b0;
    redir_jr = 1'b0; redir_jal = 1'b0; redir_br = 1'b0;
    redir_rs = '0; dec_pc_plus4 = '0; dec_index = '0; dec_imm = '0;

    #2;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // reset release: BOOT cycle, then back-to-back fetch from RESET_PC
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    sb_armed = 1'b1;
    sb_restart(32'h0);
    sb_topup();
    #3;
    check("boot_req", 32'(imem_req), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      #3;
      check("run_req", 32'(imem_req), 32'd1);
      check("run_addr", imem_addr, 32'((i - 1) * 4));
      check("run_valid", 32'(if_valid), 32'(i >= 3));
      if (i >= 3) check("run_pc4", if_pc_plus4, 32'((i - 2) * 4));
    end

    // decode stall for 5 cycles
    for (int i = 0; i < 4; i++) next_cycle();
    next_cycle();
    if_ready = 1'b0;
    #3;
    held_instr = if_instr;
    held_pc4   = if_pc_plus4;
    check("stall_valid", 32'(if_valid), 32'd1);
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      #3;
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_instr", if_instr, held_instr);
      check("stall_pc4", if_pc_plus4, held_pc4);
    end
    next_cycle();
    if_ready = 1'b1;
    for (int i = 0; i < 10; i++) next_cycle();

    // taken beq to 0x10 + (-2 << 2) = 0x8; counted in rising edges after the redirect
    next_cycle();
    do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 26'h0, 16'hFFFE);
    next_cycle();
    if_ready = 1'b1;
    #3;
    check("br_req", 32'(imem_req), 32'd1);
    check("br_addr", imem_addr, 32'h8);
    check("br_flush_valid", 32'(if_valid), 32'd0);
    next_cycle();
    #3;
    check("br_drop_valid", 32'(if_valid), 32'd0);
    next_cycle();
    #3;
    check("br_out_valid", 32'(if_valid), 32'd1);
    check("br_out_pc4", if_pc_plus4, 32'hC);
    for (int i = 0; i < 4; i++) next_cycle();

    // jr and jal together: jr wins
    next_cycle();
    do_redirect(1'b1, 1'b1, 1'b0, 32'h100, 32'h2000_0000, 26'h3, 16'h0);
    next_cycle();
    if_ready = 1'b1;
    #3;
    check("jr_prio_addr", imem_addr, 32'h100);
    check("jr_prio_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 4; i++) next_cycle();

    next_cycle();
    do_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'hF000_0004, 26'h1, 16'h0);
    next_cycle();
    if_ready = 1'b1;
    #3;
    check("jal_addr", imem_addr, 32'hF000_0004);
    for (int i = 0; i < 4; i++) next_cycle();

    // PC wrap through the top of the address space
    next_cycle();
    do_redirect(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 26'h0, 16'h0);
    next_cycle();
    if_ready = 1'b1;
    #3;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    next_cycle();
    #3;
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    #3;
    check("wrap_addr2", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) next_cycle();

    // random backpressure and redirects
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      if ($urandom_range(0, 31) == 0) begin
        k = 3'($urandom_range(1, 7));
        do_redirect(k[0], k[1], k[2], $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    26'($urandom), 16'($urandom));
      end else begin
        if_ready = ($urandom_range(0, 3) != 0);
      end
    end
    check("random_progress", 32'(hs_cnt > 500), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // every issued request is either accepted, squashed, or still in the pipe
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if_ready = 1'b1;
    end
    next_cycle();
    if_ready = 1'b1;
    #1;
    check("perf_fetched", perf_fetched, hs_cnt);
    check("perf_squashed", perf_squashed,
          req_cnt - hs_cnt - 32'(if_valid) - 32'(prev_req));
`endif

    // reset with a request in flight
    next_cycle();
    if_ready = 1'b1;
    reset = 1'b1;
    sb_restart(32'h0);
    #3;
    check("mrst_valid", 32'(if_valid), 32'd0);
    next_cycle();
    reset = 1'b0;
    sb_topup();
    #3;
    check("mrst_boot_req", 32'(imem_req), 32'd0);
    next_cycle();
    #3;
    check("mrst_req", 32'(imem_req), 32'd1);
    check("mrst_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) next_cycle();

    // halt together with a jr: no further fetch, pc still follows the redirect
    next_cycle();
    halt     = 1'b1;
    redir_jr = 1'b1;
    redir_rs = 32'h400;
    if_ready = 1'b0;
    sb_armed = 1'b0;
    sb_restart(32'h0);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if_ready = 1'b1;
      #3;
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(if_valid), 32'd0);
      check("halt_pc", imem_addr, 32'h400);
    end

    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sb_armed = 1'b1;
    sb_restart(32'h0);
    sb_topup();
    #3;
    check("hrst_boot_req", 32'(imem_req), 32'd0);
    next_cycle();
    #3;
    check("hrst_req", 32'(imem_req), 32'd1);
    check("hrst_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) next_cycle();
    check("hrst_progress", 32'(hs_cnt > 3), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
